// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the 7-segment scan controller: segment
//                width, active-high {a,b,c,d,e,f,g} glyphs for hex 0-F, and
//                a one-hot helper for the digit enable.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int SEG_W      = 7;

    // The one-hot helper returns a vector this wide; callers cast it down to
    // their digit count, which therefore must not exceed this value.
    localparam int MAX_DIGITS = 32;
    localparam int DIG_IDX_W  = 5;

    // Segment order is {a,b,c,d,e,f,g}; 1 = lit.
    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1000111;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [DIG_IDX_W-1:0] idx);
        logic [MAX_DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational hex-to-seven-segment decoder, active-high
//                segment outputs in {a,b,c,d,e,f,g} order.
//  Ports       : i_hex  [3:0]       hex digit to display
//                o_seg  [SEG_W-1:0] segment pattern, 1 = lit
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       i_hex,
    output logic [SEG_W-1:0] o_seg
);

    always_comb begin
        o_seg = '0;
        case (i_hex)
            4'h0:    o_seg = SEG_HEX_0;
            4'h1:    o_seg = SEG_HEX_1;
            4'h2:    o_seg = SEG_HEX_2;
            4'h3:    o_seg = SEG_HEX_3;
            4'h4:    o_seg = SEG_HEX_4;
            4'h5:    o_seg = SEG_HEX_5;
            4'h6:    o_seg = SEG_HEX_6;
            4'h7:    o_seg = SEG_HEX_7;
            4'h8:    o_seg = SEG_HEX_8;
            4'h9:    o_seg = SEG_HEX_9;
            4'hA:    o_seg = SEG_HEX_A;
            4'hB:    o_seg = SEG_HEX_B;
            4'hC:    o_seg = SEG_HEX_C;
            4'hD:    o_seg = SEG_HEX_D;
            4'hE:    o_seg = SEG_HEX_E;
            default: o_seg = SEG_HEX_F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scanner for an NUM_DIGITS-digit 7-segment
//                display. A prescaler divides each digit slot into TICK_DIV
//                cycles, the first BLANK_CYC of which keep every digit off to
//                avoid ghosting. New values are staged in a pending register
//                and only become visible at a frame boundary so a frame never
//                shows a mix of old and new digits. Optional leading-zero
//                suppression.
//  Ports       : clk          system clock, rising edge
//                reset        synchronous active-high reset
//                load         one-cycle strobe, captures value_in/dp_in
//                value_in     hex digits, nibble i drives digit i
//                dp_in        decimal point per digit, 1 = lit
//                lz_blank_en  1 = suppress leading zeros (live, not latched)
//                seg          {a..g} for the active digit, registered
//                dp_out       decimal point for the active digit, registered
//                dig_en       one-hot digit enable, registered
//                frame_done   one-cycle pulse after the last slot of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank_en,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int                 c_CNT_W   = $clog2(TICK_DIV);
    localparam int                 c_IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;

    logic [SEG_W-1:0]        r_seg;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_dig_en;
    logic                    r_frame_done;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_past_blank;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic                    w_lz_run;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [3:0]              w_cur_nib;
    logic                    w_cur_dp;
    logic [SEG_W-1:0]        w_cur_seg;
    logic [NUM_DIGITS-1:0]   w_cur_onehot;
    logic                    w_show;

    assign w_slot_end  = (r_cnt == c_CNT_MAX);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_MAX);

    // With no blank interval the comparison would be trivially true, so the
    // window logic collapses to a constant instead.
    if (BLANK_CYC > 0) begin : g_blank
        assign w_past_blank = (r_cnt >= c_CNT_W'(BLANK_CYC));
    end else begin : g_no_blank
        assign w_past_blank = 1'b1;
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign w_nib[gi] = r_disp_val[4*gi +: 4];
    end

    // A digit is a leading zero when it and every more-significant digit
    // carry a zero nibble and no decimal point. Walk down from the top digit
    // and stop at the first one that has something to show. Digit 0 always
    // stays visible so an all-zero value still reads "0".
    always_comb begin
        w_lz_blank = '0;
        w_lz_run   = lz_blank_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lz_run      = w_lz_run & (r_disp_val[4*i +: 4] == 4'd0) & ~r_disp_dp[i];
            w_lz_blank[i] = w_lz_run;
        end
    end

    assign w_cur_nib    = w_nib[r_idx];
    assign w_cur_dp     = r_disp_dp[r_idx];
    assign w_cur_onehot = NUM_DIGITS'(onehot(DIG_IDX_W'(r_idx)));
    assign w_show       = w_past_blank & ~w_lz_blank[r_idx];

    seg7_decode u_decode (
        .i_hex (w_cur_nib),
        .o_seg (w_cur_seg)
    );

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + c_IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pending / display registers. A load always refreshes the pending
    // copy (last one wins). At the frame boundary the display takes the
    // freshest value available: a load in that very cycle beats an older
    // pending value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            if (load) begin
                r_pend_val   <= value_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end
            if (w_frame_end) begin
                if (load) begin
                    r_disp_val <= value_in;
                    r_disp_dp  <= dp_in;
                end else if (r_pend_valid) begin
                    r_disp_val <= r_pend_val;
                    r_disp_dp  <= r_pend_dp;
                end
                r_pend_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered pin drivers; everything is forced dark whenever the digit
    // enable is off so no stray segment glows during the blank interval.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg        <= '0;
            r_dp_out     <= 1'b0;
            r_dig_en     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_show) begin
                r_dig_en <= w_cur_onehot;
                r_seg    <= w_cur_seg;
                r_dp_out <= w_cur_dp;
            end else begin
                r_dig_en <= '0;
                r_seg    <= '0;
                r_dp_out <= 1'b0;
            end
        end
    end

    assign seg        = r_seg;
    assign dp_out     = r_dp_out;
    assign dig_en     = r_dig_en;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle
//                slots, 2-cycle blank). A reference model derives the pin
//                values from the elapsed cycle count since reset and checks
//                the DUT every cycle; directed literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int TICK_DIV   = 8;
    localparam int BLANK_CYC  = 2;
    localparam int FRAME      = NUM_DIGITS * TICK_DIV;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        lz_blank_en;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  dig_en;
    logic        frame_done;

    int n_total;
    int n_bad;
    int n;
    bit chk_en;

    seg7_scan_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .seg         (seg),
        .dp_out      (dp_out),
        .dig_en      (dig_en),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // {seg, dp, dig_en} for the cycle after elapsed-cycle t.
    function automatic logic [11:0] model_out(input int t, input logic [15:0] disp,
                                              input logic [3:0] dpd, input logic lz);
        int   phase;
        int   slot;
        logic [3:0] nib;
        bit   blanked;
        phase   = t % TICK_DIV;
        slot    = (t / TICK_DIV) % NUM_DIGITS;
        nib     = 4'((disp >> (4 * slot)) & 16'hF);
        blanked = lz && (slot > 0) && ((disp >> (4 * slot)) == 16'h0) && ((dpd >> slot) == 4'h0);
        if ((phase >= BLANK_CYC) && !blanked)
            return {glyph(nib), dpd[slot], 4'(1 << slot)};
        return 12'h0;
    endfunction

    int          m_t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dpd, m_pdp;
    logic        m_pv;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_dig;
    logic        exp_fd;

    always @(posedge clk) begin
        if (reset) begin
            m_t     <= 0;
            m_disp  <= '0;  m_dpd <= '0;
            m_pend  <= '0;  m_pdp <= '0;  m_pv <= 1'b0;
            exp_seg <= '0;  exp_dp <= 1'b0;  exp_dig <= '0;  exp_fd <= 1'b0;
        end else begin
            {exp_seg, exp_dp, exp_dig} <= model_out(m_t, m_disp, m_dpd, lz_blank_en);
            exp_fd <= ((m_t % FRAME) == FRAME - 1);
            if (load) begin
                m_pend <= value_in;
                m_pdp  <= dp_in;
            end
            if ((m_t % FRAME) == FRAME - 1) begin
                m_disp <= load ? value_in : (m_pv ? m_pend : m_disp);
                m_dpd  <= load ? dp_in    : (m_pv ? m_pdp  : m_dpd);
                m_pv   <= 1'b0;
            end else if (load) begin
                m_pv   <= 1'b1;
            end
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("seg",        32'(seg),        32'(exp_seg));
            check("dp_out",     32'(dp_out),     32'(exp_dp));
            check("dig_en",     32'(dig_en),     32'(exp_dig));
            check("frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        n++;
    endtask

    task automatic go(input int k);
        while (n < k) tick();
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value_in = v; dp_in = d;
        tick();
        load = 1'b0;
    endtask

    int fd_cnt;
    int r0;

    initial begin
        n_total = 0; n_bad = 0; n = 0; chk_en = 1'b0; fd_cnt = 0;
        reset = 1'b1; load = 1'b0; value_in = '0; dp_in = '0; lz_blank_en = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;

        // First frame after reset: 3 dark, 6 on digit0, 2 dark, then digit1.
        for (int k = 0; k <= 64; k++) begin
            go(k);
            if (k <= 11)
                check("lit_first_frame_dig", 32'(dig_en),
                      (k < 3) ? 32'h0 : (k <= 8) ? 32'h1 : (k <= 10) ? 32'h0 : 32'h2);
            if (k >= 3 && k <= 8)
                check("lit_first_frame_seg", 32'(seg), 32'b1111110);
            if (k > 0 && frame_done) fd_cnt++;
        end
        check("lit_frame_done_count", 32'(fd_cnt), 32'd2);

        // Load mid-frame: current frame keeps the old value.
        go(70);  pulse_load(16'h4321, 4'h0);
        go(80);  check("lit_no_tearing", 32'(seg), 32'b1111110);
        go(100); check("lit_4321_d0", 32'(seg), 32'b0110000);
                 check("lit_4321_d0_en", 32'(dig_en), 32'h1);
        go(108); check("lit_4321_d1", 32'(seg), 32'b1101101);
        go(116); check("lit_4321_d2", 32'(seg), 32'b1111001);
        go(124); check("lit_4321_d3", 32'(seg), 32'b0110011);

        // Two loads in one frame: last wins.
        go(130); pulse_load(16'h1111, 4'h0);
        go(140); pulse_load(16'hABCD, 4'h0);
        go(164); check("lit_last_wins_d0", 32'(seg), 32'b0111101);
        go(172); check("lit_last_wins_d1", 32'(seg), 32'b1001110);

        // Leading-zero suppression.
        go(175); lz_blank_en = 1'b1;
        go(176); pulse_load(16'h0050, 4'h0);
        go(196); check("lit_lz_d0_seg", 32'(seg), 32'b1111110);
                 check("lit_lz_d0_en", 32'(dig_en), 32'h1);
        go(204); check("lit_lz_d1_seg", 32'(seg), 32'b1011011);
                 check("lit_lz_d1_en", 32'(dig_en), 32'h2);
        go(212); check("lit_lz_d2_blank", 32'(dig_en), 32'h0);
        for (int k = 217; k <= 224; k++) begin
            go(k);
            check("lit_lz_d3_blank", 32'(dig_en), 32'h0);
        end
        go(226); pulse_load(16'h0000, 4'h0);
        go(260); check("lit_lz_zero_d0", 32'(dig_en), 32'h1);
        go(268); check("lit_lz_zero_d1", 32'(dig_en), 32'h0);
                 check("lit_lz_zero_d1_seg", 32'(seg), 32'h0);
        go(276); check("lit_lz_zero_d2", 32'(dig_en), 32'h0);
        go(284); check("lit_lz_zero_d3", 32'(dig_en), 32'h0);

        // Reset mid-frame at idx=2, cnt=5 discards a pending value.
        go(290); pulse_load(16'h9999, 4'h0);
        go(309); reset = 1'b1;
        tick();
        check("lit_rst_seg",  32'(seg),        32'h0);
        check("lit_rst_dig",  32'(dig_en),     32'h0);
        check("lit_rst_dp",   32'(dp_out),     32'h0);
        check("lit_rst_fd",   32'(frame_done), 32'h0);
        reset = 1'b0;
        r0 = n;
        for (int k = 0; k <= 3; k++) begin
            go(r0 + k);
            check("lit_rst_first_slot", 32'(dig_en), (k < 3) ? 32'h0 : 32'h1);
        end
        go(r0 + 36); check("lit_rst_pend_clr", 32'(seg), 32'b1111110);
        go(r0 + 44); check("lit_rst_pend_clr_d1", 32'(dig_en), 32'h0);
        lz_blank_en = 1'b0;

        // Load coinciding with the frame boundary goes straight to display.
        go(r0 + 95);  pulse_load(16'h00F0, 4'h0);
        go(r0 + 100); check("lit_bnd_d0", 32'(seg), 32'b1111110);
        go(r0 + 108); check("lit_bnd_d1", 32'(seg), 32'b1000111);
                      check("lit_bnd_d1_en", 32'(dig_en), 32'h2);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            value_in = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 99) == 0) lz_blank_en = ~lz_blank_en;
            reset    = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;
        load  = 1'b0;
        tick();
        chk_en = 1'b0;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
